// File: rtl/addr_pkg.sv
// Shared definitions for the address sequencer: FSM state codes, source-select
// encodings and the default exception-vector base.
package addr_pkg;

    // FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Address source select encodings; vector k is selected by SEL_VEC0 + k
    localparam logic [2:0] SEL_ALU    = 3'd0;
    localparam logic [2:0] SEL_ALUOUT = 3'd1;
    localparam logic [2:0] SEL_VEC0   = 3'd2;

    localparam int unsigned VEC_BASE_DEFAULT = 253;

    // Width of the latched vector index (sel is 3 bits, so k never exceeds 5)
    localparam int unsigned IDX_W = 3;

endpackage

// File: rtl/addr_src_mux.sv
// Combinational address-source selection for addr_sequencer. Picks the ALU
// result, the ALUOut register or an exception-vector address; any other select
// value yields address zero as a plain (non-vector) access.
module addr_src_mux
    import addr_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned VEC_BASE = VEC_BASE_DEFAULT,
    parameter int unsigned NUM_VEC  = 3
) (
    input  logic [2:0]        sel_i,
    input  logic [ADDR_W-1:0] alu_result_i,
    input  logic [ADDR_W-1:0] aluout_data_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              is_vec_o,
    output logic [IDX_W-1:0]  vec_idx_o
);

    logic [IDX_W-1:0] idx;

    // Decode sel into an address plus vector flag/index; vector addresses wrap at ADDR_W
    always_comb begin
        addr_o    = '0;
        is_vec_o  = 1'b0;
        vec_idx_o = '0;
        idx       = sel_i - SEL_VEC0;
        case (sel_i)
            SEL_ALU:    addr_o = alu_result_i;
            SEL_ALUOUT: addr_o = aluout_data_i;
            default: begin
                if (32'(idx) < NUM_VEC) begin
                    addr_o    = ADDR_W'(VEC_BASE) + ADDR_W'(idx);
                    is_vec_o  = 1'b1;
                    vec_idx_o = idx;
                end
            end
        endcase
    end

endmodule

// File: rtl/addr_sequencer.sv
// Memory-address sequencer: latches a selected address on start, issues a held
// memory request, waits for mem_ack with a bounded timeout and pulses done.
// Vector fetches capture the returned byte into vec_target.
// Optional feature: define ADDR_SEQ_ALIGN_CHECK_EN to add word_acc/misalign_err;
// a misaligned word access then skips the memory request entirely.
module addr_sequencer
    import addr_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned VEC_BASE = VEC_BASE_DEFAULT,
    parameter int unsigned NUM_VEC  = 3,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        sel,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] aluout_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W-1:0] vec_target,
    output logic              busy,
    output logic              done,
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
    input  logic              word_acc,
    output logic              misalign_err,
`endif
    output logic              timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              vec_q, vec_d;
    logic [IDX_W-1:0]  vec_idx_q, vec_idx_d;
    logic [ADDR_W-1:0] vec_target_q, vec_target_d;
    logic              mem_req_q, mem_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tout_q, tout_d;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
    logic              misalign_q, misalign_d;
`endif

    logic [ADDR_W-1:0] src_addr;
    logic              src_vec;
    logic [IDX_W-1:0]  src_idx;

    addr_src_mux #(
        .ADDR_W   (ADDR_W),
        .VEC_BASE (VEC_BASE),
        .NUM_VEC  (NUM_VEC)
    ) u_src_mux (
        .sel_i         (sel),
        .alu_result_i  (alu_result),
        .aluout_data_i (aluout_data),
        .addr_o        (src_addr),
        .is_vec_o      (src_vec),
        .vec_idx_o     (src_idx)
    );

    // Next-state logic; outputs are registered from the next state so they align with it
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        vec_d        = vec_q;
        vec_idx_d    = vec_idx_q;
        vec_target_d = vec_target_q;
        tout_d       = tout_q;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
        misalign_d   = misalign_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mem_addr_d = src_addr;
                    vec_d      = src_vec;
                    vec_idx_d  = src_idx;
                    state_d    = ST_REQ;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
                    if (word_acc && (src_addr[1:0] != 2'b00)) begin
                        misalign_d = 1'b1;
                        state_d    = ST_DONE;
                    end
`endif
                end
            end
            ST_REQ: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack on the expiring cycle still wins over the timeout
                if (mem_ack) begin
                    state_d = ST_DONE;
                    if (vec_q && (32'(vec_idx_q) < NUM_VEC)) begin
                        vec_target_d = ADDR_W'(mem_rdata);
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        mem_req_d = (state_d == ST_REQ) || (state_d == ST_WAIT);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            vec_q        <= 1'b0;
            vec_idx_q    <= '0;
            vec_target_q <= '0;
            mem_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tout_q       <= 1'b0;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            vec_q        <= vec_d;
            vec_idx_q    <= vec_idx_d;
            vec_target_q <= vec_target_d;
            mem_req_q    <= mem_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tout_q       <= tout_d;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_req     = mem_req_q;
    assign vec_target  = vec_target_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = tout_q;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
    assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_addr_sequencer.sv
// Scoreboard bench for addr_sequencer: stimulus pushes expected completions,
// a monitor pops and compares them on every done pulse.
module tb_addr_sequencer;

    localparam int ADDR_W   = 32;
    localparam int VEC_BASE = 253;
    localparam int NUM_VEC  = 3;
    localparam int TIMEOUT  = 15;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [2:0]        sel;
    logic [ADDR_W-1:0] alu_result;
    logic [ADDR_W-1:0] aluout_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic [ADDR_W-1:0] vec_target;
    logic              busy;
    logic              done;
    logic              timeout_err;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
    logic              word_acc;
    logic              misalign_err;
`endif

    addr_sequencer #(
        .ADDR_W   (ADDR_W),
        .VEC_BASE (VEC_BASE),
        .NUM_VEC  (NUM_VEC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .sel          (sel),
        .alu_result   (alu_result),
        .aluout_data  (aluout_data),
        .mem_addr     (mem_addr),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .vec_target   (vec_target),
        .busy         (busy),
        .done         (done),
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
        .word_acc     (word_acc),
        .misalign_err (misalign_err),
`endif
        .timeout_err  (timeout_err)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] vt;
        logic              tout;
        logic              mis;
        int                done_cyc;
        int                req_cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference state: sticky flags and last captured vector byte
    logic [ADDR_W-1:0] vt_model   = '0;
    logic              tout_model = 1'b0;
    logic              mis_model  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Address the specification assigns to each select value
    function automatic logic [ADDR_W-1:0] ref_addr(input int s, input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] b);
        longint unsigned v;
        if (s == 0) return a;
        if (s == 1) return b;
        if (s - 2 < NUM_VEC) begin
            v = longint'(VEC_BASE) + longint'(s - 2);
            return v[ADDR_W-1:0];
        end
        return '0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_vec_target"}, vec_target, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
        check({tag, "_misalign_err"}, misalign_err, 0);
`endif
    endtask

    // One access, entered and left on a falling edge. ack_at: WAIT cycle of the ack
    // (0 or > TIMEOUT means never). noise: ack pulses in REQ/DONE that must be ignored.
    task automatic run_txn(input int s, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                           input int ack_at, input logic [7:0] rd, input bit noise,
                           input bit busy_start, input bit wacc);
        exp_t              e;
        int                w;
        bit                tout_now;
        bit                mis_now;
        logic [ADDR_W-1:0] ad;
        ad       = ref_addr(s, a, b);
        mis_now  = ALIGN_EN && wacc && (ad[1:0] != 2'b00);
        tout_now = !mis_now && (ack_at < 1 || ack_at > TIMEOUT);
        w        = tout_now ? TIMEOUT : ack_at;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
        word_acc = wacc;
`endif
        sel         = 3'(s);
        alu_result  = a;
        aluout_data = b;
        start       = 1'b1;
        mem_ack     = 1'b0;
        if (mis_now) mis_model = 1'b1;
        else if (tout_now) tout_model = 1'b1;
        else if (s >= 2 && s - 2 < NUM_VEC) vt_model = ADDR_W'(rd);
        e.addr       = ad;
        e.vt         = vt_model;
        e.tout       = tout_model;
        e.mis        = mis_model;
        e.done_cyc   = mis_now ? cyc + 1 : cyc + 2 + w;
        e.req_cycles = mis_now ? 0 : w + 1;
        sb.push_back(e);

        @(negedge clk);
        start       = 1'b0;
        sel         = 3'($urandom);
        alu_result  = $urandom;
        aluout_data = $urandom;
        mem_ack     = noise;
        mem_rdata   = 8'($urandom);
        if (!mis_now) begin
            check("busy_in_req", busy, 1);
            check("mem_req_in_req", mem_req, 1);
            for (int j = 1; j <= w; j++) begin
                @(negedge clk);
                if (j == w) check("addr_hold", mem_addr, ad);
                mem_ack   = (j == ack_at);
                mem_rdata = (j == ack_at) ? rd : 8'($urandom);
                if (busy_start && j == 1) begin
                    start      = 1'b1;
                    sel        = 3'($urandom);
                    alu_result = $urandom;
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
            start     = 1'b0;
            mem_ack   = noise;
            mem_rdata = 8'($urandom);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_mem_req", mem_req, 0);
        check("done_seen", sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: compare every done pulse against the oldest expected completion
    initial begin
        exp_t e;
        int   req_cnt   = 0;
        bit   prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                req_cnt   = 0;
                prev_done = 1'b0;
            end else begin
                if (done) begin
                    check("done_single_cycle", prev_done, 0);
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1, expected no completion (t=%0t)",
                                 $time);
                    end else begin
                        e = sb.pop_front();
                        check("mem_addr", mem_addr, e.addr);
                        check("vec_target", vec_target, e.vt);
                        check("timeout_err", timeout_err, e.tout);
                        check("latency", cyc, e.done_cyc);
                        check("mem_req_cycles", req_cnt, e.req_cycles);
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
                        check("misalign_err", misalign_err, e.mis);
`endif
                    end
                    req_cnt = 0;
                end
                if (mem_req) req_cnt++;
                prev_done = done;
            end
        end
    end

    initial begin
        reset_n     = 1'b1;
        start       = 1'b0;
        sel         = '0;
        alu_result  = '0;
        aluout_data = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
        word_acc    = 1'b0;
`endif
        #1 reset_n = 1'b0;
        #1 check_all_zero("reset_async");
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        reset_n = 1'b1;

        // Start on the first edge after reset release; ack on first WAIT cycle
        run_txn(1, $urandom, 32'h100, 1, 8'h00, 1'b1, 1'b0, 1'b0);
        // Vector 1 fetch
        run_txn(3, $urandom, $urandom, 2, 8'hA5, 1'b0, 1'b0, 1'b0);
        // Ack on the very cycle the timeout expires counts as success
        run_txn(4, $urandom, $urandom, TIMEOUT, 8'h3C, 1'b1, 1'b0, 1'b0);
        // Out-of-range select: address 0, vec_target untouched
        run_txn(7, $urandom, $urandom, 1, 8'hEE, 1'b0, 1'b0, 1'b0);
        // Never acked: timeout, vec_target untouched
        run_txn(0, $urandom, $urandom, 0, 8'h00, 1'b1, 1'b0, 1'b0);
        // Restart and input changes while busy are ignored
        run_txn(0, 32'h0000_1234, $urandom, 3, 8'h00, 1'b0, 1'b1, 1'b0);
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
        run_txn(0, 32'h0000_0102, $urandom, 1, 8'h00, 1'b0, 1'b0, 1'b1);
        run_txn(0, 32'h0000_0104, $urandom, 1, 8'h00, 1'b0, 1'b0, 1'b1);
`endif

        // Reset during WAIT aborts with no done pulse
        sel        = 3'd2;
        alu_result = $urandom;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", busy, 1);
        reset_n = 1'b0;
        #1 check_all_zero("reset_mid_wait");
        sb.delete();
        vt_model   = '0;
        tout_model = 1'b0;
        mis_model  = 1'b0;
        @(negedge clk);
        check("no_done_in_reset", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_txn(2, $urandom, $urandom, 1, 8'h5A, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_txn($urandom_range(0, 7), $urandom, $urandom, $urandom_range(0, TIMEOUT + 1),
                    8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addr_sequencer.md
ADDR_SEQUENCER -- requirements
Module: addr_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address and data-path width.
REQ-002 Parameter VEC_BASE, default 253, SHALL set the first exception-vector address.
REQ-003 Parameter NUM_VEC, default 3, SHALL set the number of vector addresses (VEC_BASE .. VEC_BASE+NUM_VEC-1).
REQ-004 Parameter TIMEOUT, default 15, SHALL set the maximum number of wait cycles for mem_ack.
REQ-005 Ports SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  access request, sampled in IDLE only.
- sel  in  3  source: 0 alu_result, 1 aluout_data, 2+k vector k (k < NUM_VEC); others give address 0.
- alu_result  in  ADDR_W  ALU result address.
- aluout_data  in  ADDR_W  ALUOut register address.
- mem_addr  out  ADDR_W  registered memory address.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_ack  in  1  memory accepted/returned data.
- mem_rdata  in  8  byte returned by memory.
- vec_target  out  ADDR_W  zero-extended vector byte from the last vector fetch.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- timeout_err  out  1  sticky; set when the timeout expires.

Function
REQ-006 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-007 In IDLE with start=1, the block SHALL latch the selected address into mem_addr and the vector flag and index into internal registers, then go to REQ on the next edge.
REQ-008 Later changes on sel, alu_result or aluout_data SHALL NOT affect mem_addr until the next accepted start.
REQ-009 In REQ, the block SHALL assert mem_req, clear the wait counter and go to WAIT.
REQ-010 In WAIT, the block SHALL hold mem_req=1 and increment the wait counter each cycle.
REQ-011 mem_ack=1 in WAIT SHALL move the FSM to DONE.
REQ-012 When the counter reaches TIMEOUT without mem_ack, the block SHALL set timeout_err and move to DONE.
REQ-013 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success; timeout_err SHALL NOT be set.
REQ-014 mem_ack outside WAIT SHALL be ignored.
REQ-015 On a successful vector access, vec_target SHALL capture {zeros, mem_rdata} on the ack edge; non-vector accesses and timeouts SHALL leave vec_target unchanged.
REQ-016 In DONE, the block SHALL drop mem_req, pulse done for exactly one cycle and return to IDLE.
REQ-017 Minimum latency from start to done SHALL be 3 cycles (ack on the first WAIT cycle).
REQ-018 start while busy=1 SHALL be ignored, with no queuing.
REQ-019 A vector address SHALL equal VEC_BASE+k computed at ADDR_W bits, wrapping modulo 2^ADDR_W.
REQ-020 sel values of 2+NUM_VEC or above SHALL give mem_addr=0 and still run a normal non-vector access.
REQ-021 timeout_err SHALL clear only on reset.

Reset
REQ-022 Asserting reset_n=0 SHALL immediately force IDLE, mem_addr=0, mem_req=0, vec_target=0, busy=0, done=0, timeout_err=0 and wait counter=0.
REQ-023 Reset in the middle of an access SHALL abort it with no done pulse.
REQ-024 After reset deassertion, a start SHALL be accepted on the first clk edge.

Configuration
REQ-025 With macro ADDR_SEQ_ALIGN_CHECK_EN defined, the block SHALL add an input word_acc and a sticky output misalign_err.
REQ-026 In that configuration, a start with word_acc=1 and latched address bits [1:0]!=0 SHALL set misalign_err and go IDLE->DONE directly, with no mem_req.
REQ-027 Without ADDR_SEQ_ALIGN_CHECK_EN, neither port SHALL exist and all addresses SHALL be issued.

Structure
REQ-028 The FSM state enum, the sel encodings (SEL_ALU=0, SEL_ALUOUT=1, SEL_VEC0=2) and the default VEC_BASE SHALL live in shared package addr_pkg.
REQ-029 Address selection SHALL be a combinational sub-module, addr_src_mux, parametrised by ADDR_W, VEC_BASE and NUM_VEC.
REQ-030 The FSM, wait counter and output registers SHALL stay in addr_sequencer.

Verification
REQ-031 Bench scenario: reset; start with sel=1, aluout_data=0x100, ack on the first WAIT cycle -> mem_addr=0x100, mem_req high for 2 cycles, done 3 cycles after start.
REQ-032 Bench scenario: start with sel=3, ack with mem_rdata=0xA5 -> mem_addr=254, vec_target=0x000000A5.
REQ-033 Bench scenario: start with sel=0, never ack, TIMEOUT=15 -> timeout_err=1, done pulses once, vec_target unchanged.
REQ-034 Bench scenario: second start and changed alu_result while busy -> ignored, mem_addr stable.
REQ-035 Bench scenario: reset_n low during WAIT -> all outputs 0 immediately, no done pulse.
REQ-036 Bench scenario (ADDR_SEQ_ALIGN_CHECK_EN defined): word_acc=1 with address 0x102 -> misalign_err=1, mem_req never asserted.
